// File: rtl/square_draw_arbiter.sv
// Round-robin arbiter in front of a square drawer.
// Four requesters compete for a shared VGA pixel writer. The winner's
// coordinates and colour are latched, and a square of 2^SQ_LOG2 x 2^SQ_LOG2
// pixels is then emitted in raster order, one pixel per clock.
module square_draw_arbiter #(
    parameter int SQ_LOG2 = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [31:0] req_x,
    input  logic [27:0] req_y,
    input  logic [11:0] req_colour,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic        busy
);

    // The pixel counter holds {yoff, xoff}, so X advances fastest.
    localparam int CW = 2 * SQ_LOG2;
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_DONE
    } state_t;

    state_t          state_q;
    logic [1:0]      rr_q;        // index with highest priority next time
    logic [1:0]      win_q;       // index of the current owner
    logic [3:0]      grant_q;
    logic [3:0]      done_q;
    logic [7:0]      x_lat_q;
    logic [6:0]      y_lat_q;
    logic [2:0]      col_lat_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      vga_colour_q;
    logic            plot_q;

    logic [1:0]      win_d;
    logic [CW-1:0]   cnt_d;
    logic [7:0]      px_x_d;
    logic [6:0]      px_y_d;

    // Per-requester views of the packed request fields.
    logic [7:0] x_arr   [4];
    logic [6:0] y_arr   [4];
    logic [2:0] col_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign x_arr[gi]   = req_x[8*gi +: 8];
            assign y_arr[gi]   = req_y[7*gi +: 7];
            assign col_arr[gi] = req_colour[3*gi +: 3];
        end
    endgenerate

    // Round-robin pick: first asserted request at or after rr_q, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        win_d = rr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_q + 2'(k)]) begin
                win_d = rr_q + 2'(k);
            end
        end
    end

    // Coordinates of the pixel that follows the one currently on the bus;
    // additions are left to wrap at the VGA coordinate widths.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        px_x_d = x_lat_q + 8'(cnt_d[SQ_LOG2-1:0]);
        px_y_d = y_lat_q + 7'(cnt_d[CW-1:SQ_LOG2]);
    end

    // Control FSM with registered outputs; the VGA bus is only updated in DRAW
    // so it keeps the last pixel between squares.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            win_q        <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            col_lat_q    <= '0;
            cnt_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q   <= ST_LOAD;
                        win_q     <= win_d;
                        grant_q   <= 4'b0001 << win_d;
                        x_lat_q   <= x_arr[win_d];
                        y_lat_q   <= y_arr[win_d];
                        col_lat_q <= col_arr[win_d];
                    end
                end
                ST_LOAD: begin
                    state_q      <= ST_DRAW;
                    cnt_q        <= '0;
                    plot_q       <= 1'b1;
                    vga_x_q      <= x_lat_q;
                    vga_y_q      <= y_lat_q;
                    vga_colour_q <= col_lat_q;
                end
                ST_DRAW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        plot_q  <= 1'b0;
                        done_q  <= grant_q;
                    end else begin
                        cnt_q   <= cnt_d;
                        vga_x_q <= px_x_d;
                        vga_y_q <= px_y_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    rr_q    <= win_q + 2'd1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/square_draw_arbiter.md
SQUARE_DRAW_ARBITER -- requirements
Module: square_draw_arbiter

Interface
REQ-001 Parameter SQ_LOG2, default 2: the square side is 2^SQ_LOG2 pixels; legal range is 1..3.
REQ-002 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port resetn  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  4  per-requester draw request; bit i belongs to requester i.
REQ-005 Port req_x  input  32  packed 8-bit top-left X coordinates; requester i uses bits [8i+7:8i].
REQ-006 Port req_y  input  28  packed 7-bit top-left Y coordinates; requester i uses bits [7i+6:7i].
REQ-007 Port req_colour  input  12  packed 3-bit colours; requester i uses bits [3i+2:3i].
REQ-008 Port grant  output  4  one-hot owner of the drawer; zero when no requester owns it.
REQ-009 Port done  output  4  one-cycle completion pulse to the granted requester.
REQ-010 Port vga_x  output  8  pixel X coordinate to the VGA adapter.
REQ-011 Port vga_y  output  7  pixel Y coordinate to the VGA adapter.
REQ-012 Port vga_colour  output  3  pixel colour to the VGA adapter.
REQ-013 Port plot  output  1  write-enable to the VGA adapter.
REQ-014 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, DRAW and DONE.
REQ-016 In IDLE with req nonzero, the block SHALL select one requester by round-robin and move to LOAD on the next edge.
REQ-017 In IDLE with req zero, the FSM SHALL remain in IDLE.
REQ-018 Round-robin: search order starts at the index after the last completed grant and wraps modulo 4; after reset requester 0 has highest priority.
REQ-019 On the edge entering LOAD, the block SHALL latch the winner's x, y and colour and set grant to the winner's one-hot value.
REQ-020 grant SHALL stay stable through LOAD, DRAW and DONE.
REQ-021 LOAD SHALL last one cycle, clear the pixel counter to 0 and then go to DRAW.
REQ-022 DRAW SHALL last exactly 4^SQ_LOG2 cycles (16 at default), with plot=1 in every DRAW cycle and plot=0 in every other state.
REQ-023 Pixel counter order: the low SQ_LOG2 bits are xoff and the high SQ_LOG2 bits are yoff, so X varies fastest (raster order).
REQ-024 vga_x SHALL equal latched_x + xoff, truncated to 8 bits (wraps modulo 256, no clipping).
REQ-025 vga_y SHALL equal latched_y + yoff, truncated to 7 bits (wraps modulo 128, no clipping).
REQ-026 vga_colour SHALL equal the latched colour.
REQ-027 After the last pixel, the FSM SHALL enter DONE for one cycle, pulse done at the granted bit and update the round-robin pointer.
REQ-028 On the edge leaving DONE, grant SHALL go to zero and the FSM SHALL go to IDLE.
REQ-029 Timing: with req asserted at IDLE cycle 0, LOAD is cycle 1, plot is high in cycles 2..17, done is high in cycle 18 and IDLE is cycle 19 (default SQ_LOG2).
REQ-030 Requests SHALL be sampled only in IDLE.
REQ-031 Deasserting req after grant SHALL NOT abort the draw; it completes and still pulses done.
REQ-032 Changes on req_x, req_y or req_colour after LOAD SHALL have no effect on the draw in progress.
REQ-033 A requester holding req through done SHALL be re-arbitrated in the following IDLE cycle against the others under normal round-robin.
REQ-034 Outside DRAW, vga_x, vga_y and vga_colour SHALL hold their last values.

Reset
REQ-035 resetn low SHALL immediately, without waiting for clk, force state IDLE, grant=0, done=0, plot=0, busy=0, vga_x=0, vga_y=0, vga_colour=0, round-robin pointer to 0 and pixel counter to 0.
REQ-036 Reset during DRAW SHALL abandon the square with no done pulse, and the first post-reset grant SHALL follow REQ-018 from requester 0.

Verification
REQ-037 Single request: req=0001, x=10, y=20, colour=5 -> 16 plot cycles covering (10..13, 20..23) in raster order, then one done=0001 pulse at cycle 18.
REQ-038 All four request continuously from reset -> grant sequence 0001, 0010, 0100, 1000, 0001, with no overlap and one IDLE cycle between squares.
REQ-039 Wrap: x=254, y=126 -> vga_x sequence 254, 255, 0, 1 and vga_y values 126, 127, 0, 1.
REQ-040 req dropped and req_x changed during DRAW -> draw completes using the latched coordinates, and done pulses.
REQ-041 resetn pulsed low at the 5th DRAW cycle -> plot and grant go low asynchronously, no done pulse, and a later req=1010 is granted to requester 1 first.
